// File: rtl/reg_file_pkg.sv
// Shared definitions for the ping-pong register file: default widths, a clog2
// helper and the bank-ownership control state.
package reg_file_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_PORT_WIDTH       = 16;
  localparam int DEF_ADDR_WIDTH       = 4;
  localparam int DEF_WRITE_LANES      = 2;
  localparam int DEF_NUM_READ_PORTS   = 2;
  localparam int DEF_BLOCK_ADDR_WIDTH = DEF_ADDR_WIDTH - clog2(DEF_WRITE_LANES);

  // Bank ownership: which bank the producer fills, which one the consumers read,
  // and which banks currently hold committed data.
  typedef struct packed {
    logic       w_bank;
    logic       r_bank;
    logic [1:0] full;
  } ctrl_state_t;

endpackage

// File: rtl/reg_file_bank.sv
// One storage bank: WRITE_LANES-word block write at the clock edge and
// NUM_READ_PORTS combinational read taps.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int PORT_WIDTH     = DEF_PORT_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WRITE_LANES    = DEF_WRITE_LANES,
  parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         we,
  input  logic [ADDR_WIDTH-clog2(WRITE_LANES)-1:0]     blk_addr,
  input  logic [WRITE_LANES*PORT_WIDTH-1:0]            wdata,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]         raddr,
  output logic [NUM_READ_PORTS*PORT_WIDTH-1:0]         rdata
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int LANE_BITS = clog2(WRITE_LANES);

  logic [PORT_WIDTH-1:0] mem_q [DEPTH];
  logic [PORT_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] base;

  always_comb begin
    base = ADDR_WIDTH'(blk_addr) << LANE_BITS;
    for (int a = 0; a < DEPTH; a++) mem_d[a] = mem_q[a];
    if (we) begin
      for (int i = 0; i < WRITE_LANES; i++)
        mem_d[base + ADDR_WIDTH'(i)] = wdata[i*PORT_WIDTH +: PORT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= mem_d[a];
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      rdata[p*PORT_WIDTH +: PORT_WIDTH] = mem_q[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/pingpong_reg_file.sv
// Double-buffered register file: the producer fills one bank while consumers
// read the other; ownership swaps through commit/release handshakes.
module pingpong_reg_file
  import reg_file_pkg::*;
#(
  parameter int PORT_WIDTH     = DEF_PORT_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int WRITE_LANES    = DEF_WRITE_LANES,
  parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS
) (
  input  logic                                     clock,
  input  logic                                     resetn,
  input  logic                                     writeEnable,
  input  logic [ADDR_WIDTH-clog2(WRITE_LANES)-1:0] writeAddrTransferBlock,
  input  logic [WRITE_LANES*PORT_WIDTH-1:0]        writeData,
  input  logic                                     writeCommit,
  output logic                                     writeReady,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]     readAddr,
  input  logic                                     readRelease,
  output logic                                     readReady,
  output logic [NUM_READ_PORTS*PORT_WIDTH-1:0]     readData,
  output logic                                     readValid
);

  localparam int RDW = NUM_READ_PORTS * PORT_WIDTH;

  ctrl_state_t    ctrl_q, ctrl_d;
  logic [RDW-1:0] rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic [RDW-1:0] tap0, tap1;
  logic           write_ok, commit_ok, release_ok;

  // Handshakes: writeReady/readReady depend only on registered state. A write,
  // commit or release takes effect only at an edge where its ready is high;
  // otherwise the request is dropped (never stalled or queued).
  assign writeReady = ~ctrl_q.full[ctrl_q.w_bank];
  assign readReady  = ctrl_q.full[ctrl_q.r_bank];
  assign write_ok   = writeEnable & writeReady;

  reg_file_bank #(
    .PORT_WIDTH(PORT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .WRITE_LANES(WRITE_LANES), .NUM_READ_PORTS(NUM_READ_PORTS)
  ) u_bank0 (
    .clk(clock), .rst_n(resetn),
    .we(write_ok & ~ctrl_q.w_bank),
    .blk_addr(writeAddrTransferBlock), .wdata(writeData),
    .raddr(readAddr), .rdata(tap0)
  );

  reg_file_bank #(
    .PORT_WIDTH(PORT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .WRITE_LANES(WRITE_LANES), .NUM_READ_PORTS(NUM_READ_PORTS)
  ) u_bank1 (
    .clk(clock), .rst_n(resetn),
    .we(write_ok & ctrl_q.w_bank),
    .blk_addr(writeAddrTransferBlock), .wdata(writeData),
    .raddr(readAddr), .rdata(tap1)
  );

  // Commit needs ~full and release needs full, so when both banks pointers
  // coincide at most one of them can fire; otherwise they touch different bits.
  always_comb begin
    ctrl_d     = ctrl_q;
    commit_ok  = writeCommit & writeReady;
    release_ok = readRelease & readReady;
    if (commit_ok) begin
      ctrl_d.full[ctrl_q.w_bank] = 1'b1;
      ctrl_d.w_bank              = ~ctrl_q.w_bank;
    end
    if (release_ok) begin
      ctrl_d.full[ctrl_q.r_bank] = 1'b0;
      ctrl_d.r_bank              = ~ctrl_q.r_bank;
    end
    rdata_d  = ctrl_q.r_bank ? tap1 : tap0;
    rvalid_d = readReady;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ctrl_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign readData  = rdata_q;
  assign readValid = rvalid_q;

endmodule

// File: tb/tb_pingpong_reg_file.sv
// Self-checking bench for pingpong_reg_file: directed scenarios with literal
// expectations plus randomized traffic checked against a bank/flag model.
module tb_pingpong_reg_file;

  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int WL  = 2;
  localparam int NRP = 2;
  localparam int BAW = 3;
  localparam int DEPTH = 16;

  logic               clock;
  logic               resetn;
  logic               writeEnable;
  logic [BAW-1:0]     writeAddrTransferBlock;
  logic [WL*W-1:0]    writeData;
  logic               writeCommit;
  logic               writeReady;
  logic [NRP*AW-1:0]  readAddr;
  logic               readRelease;
  logic               readReady;
  logic [NRP*W-1:0]   readData;
  logic               readValid;

  int checks = 0;
  int errors = 0;

  pingpong_reg_file dut (
    .clock(clock), .resetn(resetn),
    .writeEnable(writeEnable), .writeAddrTransferBlock(writeAddrTransferBlock),
    .writeData(writeData), .writeCommit(writeCommit), .writeReady(writeReady),
    .readAddr(readAddr), .readRelease(readRelease), .readReady(readReady),
    .readData(readData), .readValid(readValid)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [W-1:0]     m_mem [2][DEPTH];
  int               m_wb, m_rb;
  bit               m_full [2];
  logic [NRP*W:0]   exp_q [$];   // {readValid, readData} expected after each edge

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++) m_mem[b][a] = '0;
      m_full[b] = 1'b0;
    end
    m_wb = 0;
    m_rb = 0;
    exp_q.delete();
  endtask

  always @(negedge resetn) model_reset();

  always @(posedge clock) begin
    if (resetn === 1'b1) begin
      bit           wr_rdy, rd_rdy;
      logic [NRP*W:0] e;
      int           old_wb, old_rb;
      wr_rdy = !m_full[m_wb];
      rd_rdy = m_full[m_rb];
      old_wb = m_wb;
      old_rb = m_rb;
      e = '0;
      e[NRP*W] = rd_rdy;
      for (int p = 0; p < NRP; p++)
        e[p*W +: W] = m_mem[old_rb][int'(readAddr[p*AW +: AW])];
      exp_q.push_back(e);
      if (writeEnable && wr_rdy)
        for (int i = 0; i < WL; i++)
          m_mem[old_wb][int'(writeAddrTransferBlock) * WL + i] = writeData[i*W +: W];
      if (writeCommit && wr_rdy) begin
        m_full[old_wb] = 1'b1;
        m_wb = 1 - old_wb;
      end
      if (readRelease && rd_rdy) begin
        m_full[old_rb] = 1'b0;
        m_rb = 1 - old_rb;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [NRP*W:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check("cmp_writeReady", 32'(writeReady), 32'(!m_full[m_wb]));
    check("cmp_readReady", 32'(readReady), 32'(m_full[m_rb]));
    check("cmp_readValid", 32'(readValid), 32'(e[NRP*W]));
    for (int p = 0; p < NRP; p++)
      check($sformatf("cmp_readData%0d", p), 32'(readData[p*W +: W]), 32'(e[p*W +: W]));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive_write(input int blk, input logic [W-1:0] hi, input logic [W-1:0] lo);
    writeEnable = 1'b1;
    writeAddrTransferBlock = BAW'(blk);
    writeData = {hi, lo};
    step();
    writeEnable = 1'b0;
  endtask

  task automatic drive_commit();
    writeCommit = 1'b1;
    step();
    writeCommit = 1'b0;
  endtask

  task automatic drive_release();
    readRelease = 1'b1;
    step();
    readRelease = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_writeReady"}, 32'(writeReady), 32'd1);
    check({tag, "_readReady"}, 32'(readReady), 32'd0);
    check({tag, "_readValid"}, 32'(readValid), 32'd0);
    check({tag, "_readData"}, 32'(readData), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    writeEnable = 1'b0;
    writeAddrTransferBlock = '0;
    writeData = '0;
    writeCommit = 1'b0;
    readAddr = '0;
    readRelease = 1'b0;
    model_reset();

    // Reset
    repeat (3) step();
    check_idle_outputs("reset_hold");
    resetn = 1'b1;
    step();
    check_idle_outputs("reset_release");

    // Fill bank0, commit, read
    for (int k = 0; k < 8; k++) drive_write(k, W'(2*k+1), W'(2*k));
    drive_commit();
    check("fill_readReady", 32'(readReady), 32'd1);
    readAddr = {4'd5, 4'd4};
    step();
    check("fill_readData", 32'(readData), 32'h0005_0004);
    check("fill_readValid", 32'(readValid), 32'd1);

    // Overlap: fill bank1 while bank0 is read
    for (int k = 0; k < 8; k++) drive_write(k, W'(16'h100 + 2*k+1), W'(16'h100 + 2*k));
    check("overlap_bank0_unchanged", 32'(readData), 32'h0005_0004);
    drive_commit();
    readAddr = {4'd2, 4'd3};
    step();
    check("overlap_bank0_addr3", 32'(readData), 32'h0002_0003);
    drive_release();
    step();
    check("overlap_bank1_addr3", 32'(readData), 32'h0102_0103);

    // Backpressure: both banks full
    for (int k = 0; k < 8; k++) drive_write(k, W'(16'h200 + 2*k+1), W'(16'h200 + 2*k));
    drive_commit();
    check("bp_writeReady_low", 32'(writeReady), 32'd0);
    writeEnable = 1'b1;
    writeAddrTransferBlock = '0;
    writeData = {16'hDEAD, 16'hDEAD};
    writeCommit = 1'b1;
    step();
    writeEnable = 1'b0;
    writeCommit = 1'b0;
    check("bp_still_blocked", 32'(writeReady), 32'd0);
    drive_release();
    check("bp_writeReady_back", 32'(writeReady), 32'd1);
    readAddr = {4'd1, 4'd0};
    step();
    check("bp_bank0_old_data", 32'(readData), 32'h0201_0200);

    // Simultaneous commit + release with bank0 full, bank1 empty
    writeCommit = 1'b1;
    readRelease = 1'b1;
    step();
    writeCommit = 1'b0;
    readRelease = 1'b0;
    check("simul_writeReady", 32'(writeReady), 32'd1);
    check("simul_readReady", 32'(readReady), 32'd1);
    readAddr = {4'd2, 4'd3};
    step();
    check("simul_rbank1_data", 32'(readData), 32'h0102_0103);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      writeEnable = 1'($urandom_range(0, 1));
      writeAddrTransferBlock = BAW'($urandom_range(0, 7));
      writeData = $urandom;
      writeCommit = ($urandom_range(0, 7) == 0);
      readRelease = ($urandom_range(0, 7) == 0);
      readAddr = NRP*AW'($urandom);
      step();
    end
    writeEnable = 1'b0;
    writeCommit = 1'b0;
    readRelease = 1'b0;
    step();

    // Async reset between edges, mid-fill
    for (int k = 0; k < 3; k++) drive_write(k, W'($urandom), W'($urandom));
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clock);
    resetn = 1'b1;
    drive_write(0, 16'h00AA, 16'h00BB);
    drive_commit();
    readAddr = {4'd1, 4'd0};
    step();
    check("post_reset_new_data", 32'(readData), 32'h00AA_00BB);
    readAddr = {4'd3, 4'd2};
    step();
    check("post_reset_old_cleared", 32'(readData), 32'h0000_0000);
    check("post_reset_readValid", 32'(readValid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
